// File: rtl/micro_op_sequencer_pkg.sv
// Shared operation codes, instruction opcode encodings and sequencer state
// for the micro-op sequencer and its decode ROM.
package micro_op_sequencer_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [3:0] OPER_NOP            = 4'd0;
  localparam logic [3:0] OPER_READ_REGS      = 4'd1;
  localparam logic [3:0] OPER_ENABLE_ALU_RUN = 4'd2;
  localparam logic [3:0] OPER_WRITE_REG      = 4'd3;
  localparam logic [3:0] OPER_SET_PC         = 4'd4;
  localparam logic [3:0] OPER_READ_INST      = 4'd5;
  localparam logic [3:0] OPER_READ_MEM       = 4'd6;
  localparam logic [3:0] OPER_WRITE_MEM      = 4'd7;
  localparam logic [3:0] OPER_PUSH_TO_STACK  = 4'd8;
  localparam logic [3:0] OPER_POP_FROM_STACK = 4'd9;
  localparam logic [3:0] OPER_HALT           = 4'd10;
  localparam logic [3:0] OPER_ILLEGAL        = 4'd11;
  localparam logic [3:0] OPER_IRQ_ENTRY      = 4'd12;

  // Opcode lives in the top OPC_W bits of the instruction word.
  localparam logic [OPC_W-1:0] OP_ADD     = 5'd0;
  localparam logic [OPC_W-1:0] OP_RCL     = 5'd10;
  localparam logic [OPC_W-1:0] OP_JMP     = 5'd11;
  localparam logic [OPC_W-1:0] OP_JC      = 5'd13;
  localparam logic [OPC_W-1:0] OP_CMP     = 5'd14;
  localparam logic [OPC_W-1:0] OP_TEST    = 5'd15;
  localparam logic [OPC_W-1:0] OP_SETC    = 5'd16;
  localparam logic [OPC_W-1:0] OP_CLC     = 5'd17;
  localparam logic [OPC_W-1:0] OP_LDIL    = 5'd18;
  localparam logic [OPC_W-1:0] OP_SETADDH = 5'd21;
  localparam logic [OPC_W-1:0] OP_GETDATA = 5'd22;
  localparam logic [OPC_W-1:0] OP_SETDATA = 5'd23;
  localparam logic [OPC_W-1:0] OP_MOV     = 5'd24;
  localparam logic [OPC_W-1:0] OP_POP     = 5'd25;
  localparam logic [OPC_W-1:0] OP_PUSH    = 5'd26;
  localparam logic [OPC_W-1:0] OP_HALT    = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/micro_op_sequencer_rom.sv
// Combinational decode of an instruction word into its micro-op sequence,
// sequence length and illegal flag.
module micro_op_rom
  import micro_op_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned OPER_W    = 4,
  parameter int unsigned MAX_STEPS = 4,
  parameter int unsigned LEN_W     = 3
) (
  input  logic [INSTR_W-1:0]                ir,
  output logic [MAX_STEPS-1:0][OPER_W-1:0]  codes,
  output logic [LEN_W-1:0]                  len,
  output logic                              illegal
);

  logic [OPC_W-1:0] opc;
  logic             unused_operand;

  assign opc            = ir[INSTR_W-1 -: OPC_W];
  assign unused_operand = ^ir[INSTR_W-OPC_W-1:0];

  always_comb begin
    for (int i = 0; i < int'(MAX_STEPS); i++) codes[i] = OPER_W'(OPER_NOP);
    len     = LEN_W'(1);
    illegal = 1'b0;
    case (opc) inside
      [OP_ADD:OP_RCL]: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_ENABLE_ALU_RUN);
        codes[2] = OPER_W'(OPER_WRITE_REG);  codes[3] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(4);
      end
      [OP_JMP:OP_JC]: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_ENABLE_ALU_RUN);
        codes[2] = OPER_W'(OPER_SET_PC);     codes[3] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(4);
      end
      OP_CMP, OP_TEST: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_ENABLE_ALU_RUN);
        codes[2] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(3);
      end
      OP_SETC, OP_CLC: begin
        codes[0] = OPER_W'(OPER_ENABLE_ALU_RUN); codes[1] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(2);
      end
      [OP_LDIL:OP_SETADDH]: begin
        codes[0] = OPER_W'(OPER_WRITE_REG);  codes[1] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(2);
      end
      OP_GETDATA: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_READ_MEM);
        codes[2] = OPER_W'(OPER_WRITE_REG);  codes[3] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(4);
      end
      OP_SETDATA: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_WRITE_MEM);
        codes[2] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(3);
      end
      OP_MOV: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_WRITE_REG);
        codes[2] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(3);
      end
      OP_POP: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_POP_FROM_STACK);
        codes[2] = OPER_W'(OPER_WRITE_REG);  codes[3] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(4);
      end
      OP_PUSH: begin
        codes[0] = OPER_W'(OPER_READ_REGS);  codes[1] = OPER_W'(OPER_PUSH_TO_STACK);
        codes[2] = OPER_W'(OPER_READ_INST);
        len = LEN_W'(3);
      end
      OP_HALT: codes[0] = OPER_W'(OPER_HALT);
      default: begin
        codes[0] = OPER_W'(OPER_ILLEGAL);
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/micro_op_sequencer.sv
// Expands accepted instruction words into micro-op sequences issued under a
// valid/ack handshake. Optional interrupt entry sequence under SEQ_IRQ_EN.
module micro_op_sequencer
  import micro_op_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned OPER_W    = 4,
  parameter int unsigned MAX_STEPS = 4,
  parameter int unsigned STEP_W    = $clog2(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] ir,
  input  logic               ir_valid,
  output logic               ir_ready,
  output logic [OPER_W-1:0]  oper_code,
  output logic               oper_valid,
  input  logic               oper_ack,
  output logic [STEP_W-1:0]  step,
  output logic               last_step,
  input  logic               flush,
  input  logic               resume,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  input  logic               irq,
  output logic               irq_ack
);

  localparam int unsigned LEN_W = STEP_W + 1;

  seq_state_e                        state, state_n;
  logic [MAX_STEPS-1:0][OPER_W-1:0]  codes_q, codes_n, rom_codes;
  logic [STEP_W-1:0]                 last_q, last_n, step_n;
  logic                              ill_q, ill_n;
  logic [LEN_W-1:0]                  rom_len;
  logic                              rom_illegal;
  logic                              ready_q, ready_n;
  logic [OPER_W-1:0]                 code_n;
  logic                              valid_n, last_step_n, busy_n, halted_n, illegal_n, irq_take;

  micro_op_rom #(
    .INSTR_W  (INSTR_W),
    .OPER_W   (OPER_W),
    .MAX_STEPS(MAX_STEPS),
    .LEN_W    (LEN_W)
  ) u_rom (
    .ir     (ir),
    .codes  (rom_codes),
    .len    (rom_len),
    .illegal(rom_illegal)
  );

`ifdef SEQ_IRQ_EN
  // A pending interrupt withholds acceptance in the same cycle.
  assign ir_ready = ready_q & ~irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign ir_ready   = ready_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      codes_q    <= '0;
      last_q     <= '0;
      ill_q      <= 1'b0;
      step       <= '0;
      oper_code  <= OPER_W'(OPER_NOP);
      oper_valid <= 1'b0;
      last_step  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      irq_ack    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state      <= state_n;
      codes_q    <= codes_n;
      last_q     <= last_n;
      ill_q      <= ill_n;
      step       <= step_n;
      oper_code  <= code_n;
      oper_valid <= valid_n;
      last_step  <= last_step_n;
      busy       <= busy_n;
      halted     <= halted_n;
      illegal    <= illegal_n;
      irq_ack    <= irq_take;
      ready_q    <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    codes_n  = codes_q;
    last_n   = last_q;
    ill_n    = ill_q;
    step_n   = step;
    irq_take = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef SEQ_IRQ_EN
        if (irq) begin
          for (int i = 0; i < int'(MAX_STEPS); i++) codes_n[i] = OPER_W'(OPER_NOP);
          codes_n[0] = OPER_W'(OPER_PUSH_TO_STACK);
          codes_n[1] = OPER_W'(OPER_IRQ_ENTRY);
          codes_n[2] = OPER_W'(OPER_READ_INST);
          last_n     = STEP_W'(2);
          ill_n      = 1'b0;
          step_n     = '0;
          irq_take   = 1'b1;
          state_n    = ST_ISSUE;
        end else
`endif
        if (ir_valid) begin
          codes_n = rom_codes;
          last_n  = STEP_W'(rom_len - LEN_W'(1));
          ill_n   = rom_illegal;
          step_n  = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          step_n  = '0;
          state_n = ST_IDLE;
        end else if (oper_ack) begin
          if (last_step) begin
            step_n  = '0;
            state_n = (oper_code == OPER_W'(OPER_HALT)) ? ST_HALTED : ST_IDLE;
          end else begin
            step_n = STEP_W'(step + 1'b1);
          end
        end
      end
      ST_HALTED: if (resume) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    code_n      = OPER_W'(OPER_NOP);
    valid_n     = 1'b0;
    last_step_n = 1'b0;
    busy_n      = 1'b0;
    halted_n    = 1'b0;
    illegal_n   = 1'b0;
    ready_n     = 1'b0;
    case (state_n)
      ST_IDLE:   ready_n = 1'b1;
      ST_ISSUE: begin
        code_n      = codes_n[step_n];
        valid_n     = 1'b1;
        busy_n      = 1'b1;
        last_step_n = (step_n == last_n);
        illegal_n   = ill_n;
      end
      ST_HALTED: halted_n = 1'b1;
      default:   ready_n = 1'b0;
    endcase
  end

endmodule
